chj_wb_arbiter: RTL and testbench

Writeback arbiter that owns the write port of the `chj_registerfile` GPR array. It merges single-cycle ALU results with multi-cycle load results from the LSU, buffering LSU results in a small FIFO. It drives registered `wen`/`waddr`/`wdata` toward the register file and drops every write to x0. It also gives decode a per-operand hazard flag covering results that are still queued or staged.

---
 rtl/chj_wb_arbiter.sv | 148 ++++++++++++++
 tb/tb_chj_wb_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chj_wb_arbiter.sv
// Writeback arbiter: merges ALU results with FIFO-buffered LSU results onto the
// register-file write port. Define WB_BYPASS_EN to bypass staged writes to decode.
module chj_wb_arbiter #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alu_valid,
  input  logic [ADDR_WIDTH-1:0]   alu_rd,
  input  logic [DATA_WIDTH-1:0]   alu_data,
  output logic                    alu_stall,
  input  logic                    lsu_valid,
  output logic                    lsu_ready,
  input  logic [ADDR_WIDTH-1:0]   lsu_rd,
  input  logic [DATA_WIDTH-1:0]   lsu_data,
  output logic                    rf_wen,
  output logic [ADDR_WIDTH-1:0]   rf_waddr,
  output logic [DATA_WIDTH-1:0]   rf_wdata,
  input  logic [ADDR_WIDTH-1:0]   chk_rs1,
  input  logic [ADDR_WIDTH-1:0]   chk_rs2,
  output logic                    hazard_rs1,
  output logic                    hazard_rs2,
  output logic                    byp_rs1_valid,
  output logic                    byp_rs2_valid,
  output logic [DATA_WIDTH-1:0]   byp_rs1_data,
  output logic [DATA_WIDTH-1:0]   byp_rs2_data,
  output logic [$clog2(DEPTH):0]  fifo_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] fifo_rd_q   [DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [3:0]            starve_q, starve_d;
  logic                  rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic                  fifo_empty, alu_take, push, pop;
  logic                  fifo_hit1, fifo_hit2, staged1, staged2;
  logic [PW-1:0]         slot_off;

  assign fifo_empty = (count_q == '0);
  assign lsu_ready  = (count_q != CW'(DEPTH));
  assign alu_stall  = (starve_q == 4'(STARVE_LIMIT)) && !fifo_empty;
  assign alu_take   = alu_valid && (alu_rd != '0);
  assign push       = lsu_valid && lsu_ready && (lsu_rd != '0);

  always_comb begin
    pop        = 1'b0;
    rf_wen_d   = 1'b0;
    rf_waddr_d = '0;
    rf_wdata_d = '0;
    if (alu_stall || (!alu_take && !fifo_empty)) begin
      pop        = 1'b1;
      rf_wen_d   = 1'b1;
      rf_waddr_d = fifo_rd_q[rd_ptr_q];
      rf_wdata_d = fifo_data_q[rd_ptr_q];
    end else if (alu_take) begin
      rf_wen_d   = 1'b1;
      rf_waddr_d = alu_rd;
      rf_wdata_d = alu_data;
    end
  end

  // Starvation only accumulates while the head is waiting behind ALU wins
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    if (pop || fifo_empty) begin
      starve_d = '0;
    end else if (alu_take && (starve_q != 4'(STARVE_LIMIT))) begin
      starve_d = starve_q + 4'd1;
    end else begin
      starve_d = starve_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= lsu_rd;
      fifo_data_q[wr_ptr_q] <= lsu_data;
    end
  end

  // A slot is live when its distance from the read pointer is below the occupancy
  always_comb begin
    fifo_hit1 = 1'b0;
    fifo_hit2 = 1'b0;
    slot_off  = '0;
    for (int s = 0; s < DEPTH; s++) begin
      slot_off = PW'(s) - rd_ptr_q;
      if ({1'b0, slot_off} < count_q) begin
        if (fifo_rd_q[PW'(s)] == chk_rs1) fifo_hit1 = 1'b1;
        if (fifo_rd_q[PW'(s)] == chk_rs2) fifo_hit2 = 1'b1;
      end
    end
  end

  assign staged1 = rf_wen_q && (rf_waddr_q == chk_rs1);
  assign staged2 = rf_wen_q && (rf_waddr_q == chk_rs2);

`ifdef WB_BYPASS_EN
  assign byp_rs1_valid = staged1 && (chk_rs1 != '0);
  assign byp_rs2_valid = staged2 && (chk_rs2 != '0);
  assign byp_rs1_data  = rf_wdata_q;
  assign byp_rs2_data  = rf_wdata_q;
  assign hazard_rs1    = (chk_rs1 != '0) && fifo_hit1;
  assign hazard_rs2    = (chk_rs2 != '0) && fifo_hit2;
`else
  assign byp_rs1_valid = 1'b0;
  assign byp_rs2_valid = 1'b0;
  assign byp_rs1_data  = '0;
  assign byp_rs2_data  = '0;
  assign hazard_rs1    = (chk_rs1 != '0) && (fifo_hit1 || staged1);
  assign hazard_rs2    = (chk_rs2 != '0) && (fifo_hit2 || staged2);
`endif

  assign rf_wen     = rf_wen_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign fifo_count = count_q;
endmodule

// File: tb/tb_chj_wb_arbiter.sv
// Self-checking bench for chj_wb_arbiter: vector table, corner-case sequences and
// random traffic compared against a queue-based reference model.
module tb_chj_wb_arbiter;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int LIMIT = 3;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid, alu_stall, lsu_valid, lsu_ready, rf_wen;
  logic [AW-1:0] alu_rd, lsu_rd, rf_waddr, chk_rs1, chk_rs2;
  logic [DW-1:0] alu_data, lsu_data, rf_wdata, byp_rs1_data, byp_rs2_data;
  logic          hazard_rs1, hazard_rs2, byp_rs1_valid, byp_rs2_valid;
  logic [2:0]    fifo_count;

  always #5 clk = ~clk;

  chj_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
    .hazard_rs1(hazard_rs1), .hazard_rs2(hazard_rs2),
    .byp_rs1_valid(byp_rs1_valid), .byp_rs2_valid(byp_rs2_valid),
    .byp_rs1_data(byp_rs1_data), .byp_rs2_data(byp_rs2_data),
    .fifo_count(fifo_count)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: pending loads as an ordered queue plus the staged write
  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } entry_t;
  entry_t        q[$];
  int            starve;
  logic          m_wen;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  typedef struct {
    logic          av;
    logic [AW-1:0] ard;
    logic [DW-1:0] ad;
    logic          lv;
    logic [AW-1:0] lrd;
    logic [DW-1:0] ld;
    logic          e_wen;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    int            e_cnt;
    logic          e_ready;
    logic          e_stall;
  } vec_t;
  vec_t vec[14];

  logic [DW-1:0] wlog[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    starve = 0;
    m_wen  = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  function automatic logic model_hazard(input logic [AW-1:0] rs);
    if (rs == '0) return 1'b0;
    foreach (q[i]) if (q[i].rd == rs) return 1'b1;
    if (!BYP && m_wen && (m_addr == rs)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic model_byp(input logic [AW-1:0] rs);
    return BYP && m_wen && (m_addr == rs) && (rs != '0);
  endfunction

  task automatic check_model();
    logic stall_exp;
    stall_exp = (starve == LIMIT) && (q.size() != 0);
    check("rf_wen", 32'(rf_wen), 32'(m_wen));
    if (m_wen) begin
      check("rf_waddr", 32'(rf_waddr), 32'(m_addr));
      check("rf_wdata", rf_wdata, m_data);
    end
    check("fifo_count", 32'(fifo_count), 32'(q.size()));
    check("lsu_ready", 32'(lsu_ready), 32'(q.size() != DEPTH));
    check("alu_stall", 32'(alu_stall), 32'(stall_exp));
    check("hazard_rs1", 32'(hazard_rs1), 32'(model_hazard(chk_rs1)));
    check("hazard_rs2", 32'(hazard_rs2), 32'(model_hazard(chk_rs2)));
    check("byp_rs1_valid", 32'(byp_rs1_valid), 32'(model_byp(chk_rs1)));
    check("byp_rs2_valid", 32'(byp_rs2_valid), 32'(model_byp(chk_rs2)));
    if (!BYP || model_byp(chk_rs1)) check("byp_rs1_data", byp_rs1_data, BYP ? m_data : 32'h0);
    if (!BYP || model_byp(chk_rs2)) check("byp_rs2_data", byp_rs2_data, BYP ? m_data : 32'h0);
  endtask

  // Next-state of the model from the rules: stall pops, else ALU, else FIFO head
  task automatic model_step();
    entry_t win;
    bit     have, popped, old_empty, stall, take;
    int     old_size;
    if (!rst) begin
      model_reset();
      return;
    end
    old_size  = q.size();
    old_empty = (old_size == 0);
    stall     = (starve == LIMIT) && !old_empty;
    take      = alu_valid && (alu_rd != '0);
    have      = 1'b0;
    popped    = 1'b0;
    win       = '{rd: '0, data: '0};
    if (stall) begin
      win = q.pop_front(); have = 1'b1; popped = 1'b1;
    end else if (take) begin
      win.rd = alu_rd; win.data = alu_data; have = 1'b1;
    end else if (!old_empty) begin
      win = q.pop_front(); have = 1'b1; popped = 1'b1;
    end
    if (lsu_valid && (old_size != DEPTH) && (lsu_rd != '0))
      q.push_back('{rd: lsu_rd, data: lsu_data});
    if (popped || old_empty) starve = 0;
    else if (take) starve = (starve + 1 > LIMIT) ? LIMIT : starve + 1;
    m_wen  = have;
    m_addr = win.rd;
    m_data = win.data;
  endtask

  task automatic apply_stimulus(input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                                input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ld,
                                input logic [AW-1:0] c1, input logic [AW-1:0] c2);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    chk_rs1 = c1; chk_rs2 = c2;
  endtask

  task automatic to_sample();
    @(negedge clk);
  endtask

  task automatic finish_cycle();
    check_model();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    to_sample();
    finish_cycle();
  endtask

  initial begin
    // alu: v rd data | lsu: v rd data | expected: wen addr data cnt ready stall
    vec[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  32'h0,        0, 1'b1, 1'b0};
    vec[1]  = '{1'b1, 5'd0,  32'h00001234, 1'b0, 5'd0, 32'h0,  1'b1, 5'd5,  32'hDEADBEEF, 0, 1'b1, 1'b0};
    vec[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  32'h0,        0, 1'b1, 1'b0};
    vec[3]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3, 32'hA3, 1'b0, 5'd0,  32'h0,        0, 1'b1, 1'b0};
    vec[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  32'h0,        1, 1'b1, 1'b0};
    vec[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd3,  32'hA3,       0, 1'b1, 1'b0};
    vec[6]  = '{1'b1, 5'd6,  32'hC6,       1'b1, 5'd4, 32'hB4, 1'b0, 5'd0,  32'h0,        0, 1'b1, 1'b0};
    vec[7]  = '{1'b1, 5'd7,  32'hD7,       1'b0, 5'd0, 32'h0,  1'b1, 5'd6,  32'hC6,       1, 1'b1, 1'b0};
    vec[8]  = '{1'b1, 5'd8,  32'hE8,       1'b0, 5'd0, 32'h0,  1'b1, 5'd7,  32'hD7,       1, 1'b1, 1'b0};
    vec[9]  = '{1'b1, 5'd9,  32'hF9,       1'b0, 5'd0, 32'h0,  1'b1, 5'd8,  32'hE8,       1, 1'b1, 1'b0};
    vec[10] = '{1'b1, 5'd10, 32'h10A,      1'b0, 5'd0, 32'h0,  1'b1, 5'd9,  32'hF9,       1, 1'b1, 1'b1};
    vec[11] = '{1'b1, 5'd10, 32'h10A,      1'b0, 5'd0, 32'h0,  1'b1, 5'd4,  32'hB4,       0, 1'b1, 1'b0};
    vec[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd10, 32'h10A,      0, 1'b1, 1'b0};
    vec[13] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  32'h0,        0, 1'b1, 1'b0};

    // Reset held while both sources are active
    rst = 1'b0;
    apply_stimulus(1'b1, 5'd5, 32'h1, 1'b1, 5'd2, 32'h2, 5'd0, 5'd0);
    model_reset();
    for (int i = 0; i < 3; i++) begin
      to_sample();
      check("reset_wen", 32'(rf_wen), 32'h0);
      check("reset_ready", 32'(lsu_ready), 32'h1);
      check("reset_count", 32'(fifo_count), 32'h0);
      check("reset_stall", 32'(alu_stall), 32'h0);
      finish_cycle();
    end
    rst = 1'b1;

    for (int i = 0; i < 14; i++) begin
      apply_stimulus(vec[i].av, vec[i].ard, vec[i].ad, vec[i].lv, vec[i].lrd, vec[i].ld, 5'd5, 5'd3);
      to_sample();
      check($sformatf("vec%0d_wen", i), 32'(rf_wen), 32'(vec[i].e_wen));
      if (vec[i].e_wen) begin
        check($sformatf("vec%0d_addr", i), 32'(rf_waddr), 32'(vec[i].e_addr));
        check($sformatf("vec%0d_data", i), rf_wdata, vec[i].e_data);
      end
      check($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(vec[i].e_cnt));
      check($sformatf("vec%0d_ready", i), 32'(lsu_ready), 32'(vec[i].e_ready));
      check($sformatf("vec%0d_stall", i), 32'(alu_stall), 32'(vec[i].e_stall));
      finish_cycle();
    end

    // FIFO fill under continuous ALU traffic, refused push at full, wrap-around drain
    begin
      int pushed = 0;
      wlog.delete();
      for (int k = 0; k < 60; k++) begin
        apply_stimulus(k < 30, 5'd7, 32'h7000 + 32'(k), pushed < 5, 5'(pushed + 1),
                       32'h11 * 32'(pushed + 1), 5'd2, 5'd7);
        to_sample();
        if (k == 4) begin
          check("full_ready", 32'(lsu_ready), 32'h0);
          check("full_count", 32'(fifo_count), 32'h4);
          check("full_stall", 32'(alu_stall), 32'h1);
        end
        if (k == 5) begin
          check("after_pop_ready", 32'(lsu_ready), 32'h1);
          check("after_pop_count", 32'(fifo_count), 32'h3);
          check("first_load_wen", 32'(rf_wen), 32'h1);
          check("first_load_addr", 32'(rf_waddr), 32'h1);
        end
        if (rf_wen && (rf_waddr >= 5'd1) && (rf_waddr <= 5'd5)) wlog.push_back(rf_wdata);
        if (lsu_valid && lsu_ready) pushed++;
        finish_cycle();
      end
      check("load_write_count", 32'(wlog.size()), 32'd5);
      for (int i = 0; i < 5; i++)
        check($sformatf("load_order%0d", i), (i < wlog.size()) ? wlog[i] : 32'hFFFFFFFF, 32'h11 * 32'(i + 1));
    end

    // Hazard tracking of a queued load through staging
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99, 5'd9, 5'd0);
    to_sample();
    check("haz_before", 32'(hazard_rs1), 32'h0);
    finish_cycle();
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd0);
    to_sample();
    check("haz_queued", 32'(hazard_rs1), 32'h1);
    check("haz_rs2_zero", 32'(hazard_rs2), 32'h0);
    finish_cycle();
    to_sample();
    check("haz_staged", 32'(hazard_rs1), 32'(!BYP));
    check("byp_staged_valid", 32'(byp_rs1_valid), 32'(BYP));
    check("byp_staged_data", byp_rs1_data, BYP ? 32'h99 : 32'h0);
    finish_cycle();
    to_sample();
    check("haz_after", 32'(hazard_rs1), 32'h0);
    finish_cycle();

    // Reset with three queued loads: nothing stale may ever be written
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 5'd7, 32'h70 + 32'(i), 1'b1, 5'(i + 1), 32'hA0 + 32'(i), 5'd1, 5'd2);
      cycle();
    end
    rst = 1'b0;
    model_reset();
    #1;
    check("midreset_count", 32'(fifo_count), 32'h0);
    check("midreset_wen", 32'(rf_wen), 32'h0);
    check("midreset_ready", 32'(lsu_ready), 32'h1);
    cycle();
    cycle();
    rst = 1'b1;
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
    for (int i = 0; i < 8; i++) begin
      to_sample();
      check("no_stale_wen", 32'(rf_wen), 32'h0);
      finish_cycle();
    end

    // Random traffic with a small register range to provoke hazards and collisions
    for (int i = 0; i < 400; i++) begin
      apply_stimulus(($urandom % 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                     ($urandom % 2) != 0, 5'($urandom_range(0, 7)), $urandom,
                     5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
